io_timer: RTL and testbench

IO_TIMER -- requirements
Module: io_timer

---
 rtl/io_pkg.sv | 40 ++++
 rtl/io_timer_presc.sv | 44 ++++
 rtl/io_timer.sv | 147 ++++++++++++++
 tb/tb_io_timer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared definitions for the io_timer register window: word
//            offsets, CTRL/STATUS bit positions and window geometry.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

    // Register window geometry: 32 bytes, eight 32-bit words.
    localparam int unsigned WINDOW_BYTES = 32;
    localparam int unsigned WINDOW_AW    = 5;

    // Word offsets, decoded from io_addr[4:2].
    typedef enum logic [2:0] {
        OFF_CTRL     = 3'd0,
        OFF_PRESCALE = 3'd1,
        OFF_COUNT    = 3'd2,
        OFF_COMPARE  = 3'd3,
        OFF_STATUS   = 3'd4
    } io_off_e;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AR_BIT    = 1;
    localparam int CTRL_IRQEN_BIT = 2;
    localparam int CTRL_W         = 3;

    // STATUS bit positions.
    localparam int STAT_MATCH_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;
    localparam int STAT_W         = 2;

    // True when addr falls inside the window that starts at base.
    function automatic logic io_sel(input logic [15:0] addr, input logic [15:0] base);
        return (addr >> WINDOW_AW) == (base >> WINDOW_AW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_timer_presc.sv
`default_nettype none
// ============================================================================
// Module   : io_timer_presc
// Purpose  : Prescaler for io_timer. A 16-bit counter PC runs while enabled
//            and emits a one-cycle tick when it equals PRESCALE, then
//            restarts from 0. A clear request forces PC back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module io_timer_presc (
    input  logic        clk,
    input  logic        rst,       // asynchronous, active-low
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic        hit;

    // Tick generation and next prescale-counter value; clear beats counting.
    always_comb begin
        hit  = (pc_q == prescale);
        tick = en & hit;
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = hit ? '0 : pc_q + 16'd1;
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_timer.sv
`default_nettype none
// ============================================================================
// Module   : io_timer
// Purpose  : Memory-mapped 32-bit timer with prescaler, compare match,
//            optional auto-reload and a level interrupt.
//            Registers (word offset): 0 CTRL, 1 PRESCALE, 2 COUNT,
//            3 COMPARE, 4 STATUS (write-1-to-clear).
// Config   : define IO_TIMER_OVF_EN to enable STATUS[1] OVF (set on the COUNT
//            wrap from 0xFFFFFFFF to 0, contributes to irq).
// Revision : 1.0 - initial release
// ============================================================================
module io_timer #(
    parameter logic [15:0] BASE = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,       // asynchronous, active-low
    input  logic        io_r,
    input  logic        io_w,
    input  logic [15:0] io_addr,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    output logic        irq
);

    import io_pkg::*;

    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [15:0]       presc_q,  presc_d;
    logic [31:0]       count_q,  count_d;
    logic [31:0]       cmp_q,    cmp_d;
    logic [STAT_W-1:0] status_q, status_d;

    logic              sel;
    logic [2:0]        off;
    logic              wr_ctrl, wr_presc, wr_count, wr_cmp, wr_stat;
    logic              tick;
    logic              cnt_tick;
    logic              match_evt;
    logic              ovf_evt;
    logic [STAT_W-1:0] stat_set;
    logic [STAT_W-1:0] stat_clr;

    // Byte-lane bits are irrelevant to a word-only register file.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^io_addr[1:0];

    // Address decode and per-register write strobes.
    always_comb begin
        sel      = io_sel(io_addr, BASE);
        off      = io_addr[4:2];
        wr_ctrl  = 1'b0;
        wr_presc = 1'b0;
        wr_count = 1'b0;
        wr_cmp   = 1'b0;
        wr_stat  = 1'b0;
        if (io_w && sel) begin
            case (off)
                OFF_CTRL:     wr_ctrl  = 1'b1;
                OFF_PRESCALE: wr_presc = 1'b1;
                OFF_COUNT:    wr_count = 1'b1;
                OFF_COMPARE:  wr_cmp   = 1'b1;
                OFF_STATUS:   wr_stat  = 1'b1;
                default:      ;
            endcase
        end
    end

    // Prescaler restarts whenever the period or the count is rewritten.
    io_timer_presc u_presc (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[CTRL_EN_BIT]),
        .clr      (wr_presc | wr_count),
        .prescale (presc_q),
        .tick     (tick)
    );

    // Next-state for the register file: a COUNT write swallows the tick,
    // and status set events beat a same-cycle write-1-to-clear.
    always_comb begin
        ctrl_d    = wr_ctrl  ? io_wdata[CTRL_W-1:0] : ctrl_q;
        presc_d   = wr_presc ? io_wdata[15:0]       : presc_q;
        cmp_d     = wr_cmp   ? io_wdata             : cmp_q;

        cnt_tick  = tick & ~wr_count;
        match_evt = cnt_tick & (count_q == cmp_q);
`ifdef IO_TIMER_OVF_EN
        ovf_evt   = cnt_tick & (&count_q);
`else
        ovf_evt   = 1'b0;
`endif

        count_d = count_q;
        if (wr_count) begin
            count_d = io_wdata;
        end else if (cnt_tick) begin
            if (match_evt && ctrl_q[CTRL_AR_BIT]) begin
                count_d = '0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        stat_set                 = '0;
        stat_set[STAT_MATCH_BIT] = match_evt;
        stat_set[STAT_OVF_BIT]   = ovf_evt;
        stat_clr                 = wr_stat ? io_wdata[STAT_W-1:0] : '0;
        status_d                 = (status_q & ~stat_clr) | stat_set;
    end

    // Register file state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            presc_q  <= '0;
            count_q  <= '0;
            cmp_q    <= '0;
            status_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
        end
    end

    // Combinational read mux from current register state; forced to 0 in reset.
    always_comb begin
        io_rdata = '0;
        if (rst && io_r && sel) begin
            case (off)
                OFF_CTRL:     io_rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
                OFF_PRESCALE: io_rdata = {16'h0000, presc_q};
                OFF_COUNT:    io_rdata = count_q;
                OFF_COMPARE:  io_rdata = cmp_q;
                OFF_STATUS:   io_rdata = {{(32-STAT_W){1'b0}}, status_q};
                default:      io_rdata = '0;
            endcase
        end
    end

    // Interrupt depends on registered state only.
    assign irq = ctrl_q[CTRL_IRQEN_BIT] & (|status_q);

endmodule
`default_nettype wire

// File: tb/tb_io_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_timer
// Purpose  : Self-checking bench for io_timer: directed scenarios followed
//            by random bus traffic, scored against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_timer;

    localparam logic [15:0] BASE = 16'h0100;
    localparam logic [15:0] A_CTRL = 16'h00, A_PRESC = 16'h04, A_COUNT = 16'h08,
                            A_CMP  = 16'h0C, A_STAT  = 16'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        io_r = 1'b0;
    logic        io_w = 1'b0;
    logic [15:0] io_addr = '0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        irq;

    io_timer #(.BASE(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_r     (io_r),
        .io_w     (io_w),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_q[$];
    logic        irq_q[$];

    // Behavioural view of the timer, as seen by software.
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc;
    logic [15:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic        m_match;
    logic        m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = '0; m_presc = '0; m_pc = '0; m_count = '0;
        m_cmp = '0; m_match = 1'b0; m_ovf = 1'b0;
    endfunction

    function automatic logic hit(input logic [15:0] a);
        return a[15:5] == BASE[15:5];
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        if (!rst || !hit(a)) return 32'h0;
        case (a[4:2])
            3'd0:    return {29'h0, m_ctrl};
            3'd1:    return {16'h0, m_presc};
            3'd2:    return m_count;
            3'd3:    return m_cmp;
            3'd4:    return {30'h0, m_ovf, m_match};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq();
        return m_ctrl[2] & (m_match | m_ovf);
    endfunction

    // One clock edge of the timer rules, applied to the software view.
    function automatic void model_step(input logic w, input logic [15:0] a, input logic [31:0] d);
        logic wsel, w_ctrl, w_presc, w_count, w_cmp, w_stat;
        logic running, tick, counted, matched, wrapped;
        wsel    = w && hit(a);
        w_ctrl  = wsel && a[4:2] == 3'd0;
        w_presc = wsel && a[4:2] == 3'd1;
        w_count = wsel && a[4:2] == 3'd2;
        w_cmp   = wsel && a[4:2] == 3'd3;
        w_stat  = wsel && a[4:2] == 3'd4;
        running = m_ctrl[0];
        tick    = running && (m_pc == m_presc);
        counted = tick && !w_count;
        matched = counted && (m_count == m_cmp);
        wrapped = counted && (m_count == 32'hFFFF_FFFF);

        if (w_presc || w_count)  m_pc = '0;
        else if (tick)           m_pc = '0;
        else if (running)        m_pc = m_pc + 16'd1;

        if (w_count)                   m_count = d;
        else if (matched && m_ctrl[1]) m_count = '0;
        else if (counted)              m_count = m_count + 32'd1;

        if (w_stat && d[0]) m_match = 1'b0;
        if (w_stat && d[1]) m_ovf   = 1'b0;
        if (matched)        m_match = 1'b1;
`ifdef IO_TIMER_OVF_EN
        if (wrapped)        m_ovf   = 1'b1;
`endif

        if (w_ctrl)  m_ctrl  = d[2:0];
        if (w_presc) m_presc = d[15:0];
        if (w_cmp)   m_cmp   = d;
    endfunction

    // One bus cycle: inputs applied just after a rising edge, expectations
    // queued for the monitor, model advanced at the following edge.
    task automatic cycle(input logic r, input logic w, input logic [15:0] a,
                         input logic [31:0] d, input logic do_chk,
                         input logic [31:0] exp, input string name);
        io_r = r; io_w = w; io_addr = a; io_wdata = d;
        if (r) rd_q.push_back(model_read(a));
        irq_q.push_back(model_irq());
        if (do_chk) begin
            #1;
            chk(name, io_rdata, exp);
        end
        @(posedge clk);
        if (rst) model_step(w, a, d);
        #1;
        io_r = 1'b0; io_w = 1'b0;
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] d);
        cycle(1'b0, 1'b1, BASE + off, d, 1'b0, 32'h0, "");
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, BASE, 32'h0, 1'b0, 32'h0, "");
    endtask

    task automatic rd_chk(input logic [15:0] off, input logic [31:0] exp, input string name);
        cycle(1'b1, 1'b0, BASE + off, 32'h0, 1'b1, exp, name);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        idle();
        idle();
        rst = 1'b1;
    endtask

    // Monitor: compares irq every cycle and read data whenever a read is on the bus.
    initial begin
        forever begin
            @(negedge clk);
            if (irq_q.size() > 0) chk("irq", {31'h0, irq}, {31'h0, irq_q.pop_front()});
            if (io_r) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_queue: got read with no expectation at %0t", $time);
                end else begin
                    chk("rdata", io_rdata, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] exp_stat;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state: all offsets read 0, irq low.
        for (int i = 0; i < 5; i++) rd_chk(16'(i * 4), 32'h0, "reset_read");
        chk("reset_irq", {31'h0, irq}, 32'h0);

        // Match after 3 ticks of 4 cycles, auto-reload, W1C drops irq.
        wr(A_PRESC, 32'd3);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'b111);
        n = 0;
        while (!irq && n < 40) begin idle(); n++; end
        chk("match_latency", n, 12);
        rd_chk(A_COUNT, 32'h0, "count_reloaded");
        rd_chk(A_STAT, 32'h1, "match_set");
        wr(A_STAT, 32'h1);
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        // W1C on the same cycle as a match tick: set wins.
        do_reset();
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'b011);
        repeat (3) idle();
        wr(A_STAT, 32'h1);
        rd_chk(A_STAT, 32'h1, "set_beats_clear");

        // COUNT write on a tick cycle wins, next tick PRESCALE+1 cycles later.
        do_reset();
        wr(A_PRESC, 32'd2);
        wr(A_CMP, 32'hFF);
        wr(A_CTRL, 32'b001);
        n = 0;
        while (m_pc != m_presc && n < 10) begin idle(); n++; end
        wr(A_COUNT, 32'h10);
        rd_chk(A_COUNT, 32'h10, "count_write_wins");
        rd_chk(A_COUNT, 32'h10, "count_hold1");
        rd_chk(A_COUNT, 32'h10, "count_hold2");
        rd_chk(A_COUNT, 32'h11, "next_tick");

        // Wrap from all-ones.
        do_reset();
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'b001);
        idle();
        rd_chk(A_COUNT, 32'h0, "count_wrap");
`ifdef IO_TIMER_OVF_EN
        exp_stat = 32'h3;
`else
        exp_stat = 32'h1;
`endif
        rd_chk(A_STAT, exp_stat, "ovf_flag");

        // Reset asserted mid-count discards everything.
        do_reset();
        wr(A_PRESC, 32'd1);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'b111);
        repeat (5) idle();
        rst = 1'b0;
        model_reset();
        rd_chk(A_COUNT, 32'h0, "read_in_reset");
        chk("irq_in_reset", {31'h0, irq}, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) rd_chk(16'(i * 4), 32'h0, "post_reset_read");
        rd_chk(16'h20, 32'h0, "out_of_window");

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic        r, w;
            logic [15:0] a;
            logic [31:0] d;
            int          p;
            p = $urandom_range(0, 999);
            if (p < 4) begin
                do_reset();
                continue;
            end
            r = ($urandom_range(0, 99) < 30);
            w = ($urandom_range(0, 99) < 25);
            a = BASE + 16'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 19) == 0) a = 16'($urandom);
            d = $urandom;
            case (a[4:2])
                3'd0: d = {d[31:3], 3'($urandom_range(0, 7))};
                3'd1: d = {d[31:16], 16'($urandom_range(0, 3))};
                3'd2: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                      : 32'($urandom_range(0, 12));
                3'd3: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 10));
                default: ;
            endcase
            cycle(r, w, a, d, 1'b0, 32'h0, "");
        end

        idle();
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", rd_q.size() + irq_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
